stq_fwd: RTL

Parametrised store queue with store-to-load forwarding and a handshaked post-retire drain to the Dcache; successor to the fixed 64-entry LSQ store side. Sits between dispatch/RS (allocation, age tags), the memory issue stage (store execute, load lookup), the ROB (store retire, flush) and the Dcache write port. Adds over the previous generation:
- wrap-bit age tags;
- youngest-match forwarding with an explicit stall response;
- mispredict flush;
- a retired-but-undrained region with backpressure.

---
 rtl/stq_fwd.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stq_fwd.sv
// Store queue with youngest-match store-to-load forwarding and a handshaked
// post-retire drain to the Dcache. Entries live in per-slot sub-modules.

module stq_fwd_entry #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              rdy,
  output logic              match,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   rdy <= 1'b0;
    else if (alloc) rdy <= 1'b0;
    else if (wr)    rdy <= 1'b1;
  end

  // Payload needs no reset: it is only observed once rdy is set.
  always_ff @(posedge clock) begin
    if (wr) begin
      addr <= wr_addr;
      data <= wr_data;
    end
  end

  assign match = rdy && (addr == ld_addr);
endmodule

module stq_fwd #(
  parameter int DEPTH  = 16,
  parameter int BITS   = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        disp_st,
  output logic [BITS:0]     disp_age0,
  output logic [BITS:0]     disp_age1,
  output logic [1:0]        stq_space,
  output logic              stq_empty,
  input  logic              ex_valid,
  input  logic [BITS:0]     ex_age,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_valid,
  input  logic [BITS:0]     ld_age,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_rsp_valid,
  output logic              ld_rsp_hit,
  output logic              ld_rsp_stall,
  output logic [DATA_W-1:0] ld_rsp_data,
  input  logic [1:0]        ret_num,
  input  logic              flush,
  output logic              dc_wr_valid,
  input  logic              dc_wr_ready,
  output logic [ADDR_W-1:0] dc_wr_addr,
  output logic [DATA_W-1:0] dc_wr_data
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic              hit;
    logic              stall;
    logic [DATA_W-1:0] data;
  } ld_rsp_t;

  logic [BITS:0] head, commit, tail;
  logic [BITS:0] commit_nx, n_disp, used, free;
  logic [BITS-1:0] idx0, idx1, ex_idx;
  logic drain_fire;

  logic [DEPTH-1:0]             alloc, wr, rdy, match;
  logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;

  logic [STAGES:0] vld_pipe;
  ld_rsp_t lk, rsp_q;
  logic [BITS:0]   lk_len;
  logic [BITS-1:0] lk_idx;

  logic unused_ex_wrap;
  assign unused_ex_wrap = ex_age[BITS];

  assign idx0   = tail[BITS-1:0];
  assign idx1   = idx0 + BITS'(disp_st[0]);
  assign ex_idx = ex_age[BITS-1:0];

  assign disp_age0 = tail;
  assign disp_age1 = tail + (BITS+1)'(disp_st[0]);

  assign used      = tail - head;
  assign free      = (BITS+1)'(DEPTH) - used;
  assign stq_space = (free >= (BITS+1)'(2)) ? 2'd2 : free[1:0];
  assign stq_empty = (head == tail);

  assign dc_wr_valid = (head != commit);
  assign dc_wr_addr  = e_addr[head[BITS-1:0]];
  assign dc_wr_data  = e_data[head[BITS-1:0]];
  assign drain_fire  = dc_wr_valid && dc_wr_ready;

  assign commit_nx = commit + (BITS+1)'(ret_num);
  assign n_disp    = (BITS+1)'(disp_st[0]) + (BITS+1)'(disp_st[1]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign alloc[i] = !flush && ((disp_st[0] && idx0 == BITS'(i)) ||
                                 (disp_st[1] && idx1 == BITS'(i)));
    assign wr[i]    = !flush && ex_valid && (ex_idx == BITS'(i));

    stq_fwd_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
      .clock   (clock),
      .reset_n (reset_n),
      .alloc   (alloc[i]),
      .wr      (wr[i]),
      .wr_addr (ex_addr),
      .wr_data (ex_data),
      .ld_addr (ld_addr),
      .rdy     (rdy[i]),
      .match   (match[i]),
      .addr    (e_addr[i]),
      .data    (e_data[i])
    );
  end

  // Walk oldest to youngest; a later deciding entry overrides, so the
  // youngest unexecuted-or-matching store in [head, ld_age) wins.
  always_comb begin
    lk     = '0;
    lk_idx = '0;
    lk_len = ld_age - head;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head[BITS-1:0] + BITS'(k);
      if ((BITS+1)'(k) < lk_len) begin
        if (!rdy[lk_idx]) begin
          lk.stall = 1'b1;
          lk.hit   = 1'b0;
          lk.data  = '0;
        end else if (match[lk_idx]) begin
          lk.stall = 1'b0;
          lk.hit   = 1'b1;
          lk.data  = e_data[lk_idx];
        end
      end
    end
  end

  assign vld_pipe[0] = ld_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      commit      <= '0;
      tail        <= '0;
      vld_pipe[1] <= 1'b0;
      rsp_q       <= '0;
    end else begin
      if (drain_fire) head <= head + 1'b1;
      commit      <= commit_nx;
      // Flush lands after this cycle's retire, discarding only unretired stores.
      tail        <= flush ? commit_nx : tail + n_disp;
      vld_pipe[1] <= vld_pipe[0];
      rsp_q       <= vld_pipe[0] ? lk : '0;
    end
  end

  assign ld_rsp_valid = vld_pipe[STAGES];
  assign ld_rsp_hit   = rsp_q.hit;
  assign ld_rsp_stall = rsp_q.stall;
  assign ld_rsp_data  = rsp_q.data;
endmodule
